// File: rtl/mdu_unit_pkg.sv
// Shared MDU opcode constants, controller state type and opcode classifiers.
package mdu_unit_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   function automatic logic is_mult_op(input logic [3:0] t);
      return (t == MDU_MULT) || (t == MDU_MULTU);
   endfunction

   function automatic logic is_long_op(input logic [3:0] t);
      return is_mult_op(t) || (t == MDU_DIV) || (t == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_unit_arith.sv
// Combinational multiply/divide datapath producing next HI/LO and a divide-by-zero flag.
module mdu_arith
   import mdu_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       mdu_type,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_next,
   output logic [WIDTH-1:0] lo_next,
   output logic             div_zero
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic [WIDTH-1:0]   b_safe;

   // Sign-extended operands give the signed product modulo 2^(2*WIDTH).
   assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign b_safe = (b == '0) ? WIDTH'(1) : b;

   always_comb begin
      hi_next  = '0;
      lo_next  = '0;
      div_zero = 1'b0;
      case (mdu_type)
         MDU_MULT:  {hi_next, lo_next} = prod_s;
         MDU_MULTU: {hi_next, lo_next} = prod_u;
         MDU_DIV: begin
            div_zero = (b == '0);
            if (a == MIN_VAL && b == '1) begin
               lo_next = MIN_VAL;
               hi_next = '0;
            end else begin
               lo_next = $signed(a) / $signed(b_safe);
               hi_next = $signed(a) % $signed(b_safe);
            end
         end
         MDU_DIVU: begin
            div_zero = (b == '0);
            lo_next  = a / b_safe;
            hi_next  = a % b_safe;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// MDU controller: issue FSM, latency down-counter, pending and committed HI/LO registers.
//   state   | meaning
//   ST_IDLE | accepts start; MTHI/MTLO write directly, long ops latch and go busy
//   ST_BUSY | counting down latency; starts ignored; commit on terminal count
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       mdu_type,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] rdata
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   mdu_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] pend_hi;
   logic [WIDTH-1:0] pend_lo;
   logic             pend_zero;
   logic [WIDTH-1:0] hi_next;
   logic [WIDTH-1:0] lo_next;
   logic             div_zero;

   mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .mdu_type (mdu_type),
      .a        (a),
      .b        (b),
      .hi_next  (hi_next),
      .lo_next  (lo_next),
      .div_zero (div_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         pend_hi   <= '0;
         pend_lo   <= '0;
         pend_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && is_long_op(mdu_type)) begin
                  pend_hi   <= hi_next;
                  pend_lo   <= lo_next;
                  pend_zero <= div_zero;
                  cnt       <= is_mult_op(mdu_type) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                  state     <= ST_BUSY;
               end else if (start && mdu_type == MDU_MTHI) begin
                  hi <= a;
               end else if (start && mdu_type == MDU_MTLO) begin
                  lo <= a;
               end
            end
            ST_BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= ST_IDLE;
                  // A zero divisor burns the full latency but leaves HI/LO untouched.
                  if (!pend_zero) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state == ST_BUSY);

   always_comb begin
      rdata = '0;
      if (mdu_type == MDU_MFHI)      rdata = hi;
      else if (mdu_type == MDU_MFLO) rdata = lo;
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_mdu_unit;
   import mdu_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  mdu_type = MDU_NONE;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rdata;

   mdu_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mdu_type (mdu_type),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .rdata    (rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        abort = 1'b0;
   logic [31:0] cm_hi = '0;
   logic [31:0] cm_lo = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural definitions.
   function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] ra,
                                          input logic [31:0] rb, input logic [31:0] h0,
                                          input logic [31:0] l0);
      longint          sa, sb, q, r;
      longint unsigned pu;
      logic [63:0]     res;
      res = {h0, l0};
      sa  = longint'($signed(ra));
      sb  = longint'($signed(rb));
      case (op)
         MDU_MULT:  res = 64'(sa * sb);
         MDU_MULTU: begin
            pu  = 64'(ra) * 64'(rb);
            res = pu;
         end
         MDU_DIV: if (rb != 0) begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
         end
         MDU_DIVU: if (rb != 0) res = {ra % rb, ra / rb};
         MDU_MTHI:  res = {ra, l0};
         MDU_MTLO:  res = {h0, ra};
         default: ;
      endcase
      return res;
   endfunction

   function automatic bit long_op(input logic [3:0] op);
      return op == MDU_MULT || op == MDU_MULTU || op == MDU_DIV || op == MDU_DIVU;
   endfunction

   // Scoreboard monitor: compares whenever busy drops.
   initial begin : monitor
      int   bcnt = 0;
      logic prev_busy = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy) begin
            bcnt++;
         end else if (prev_busy) begin
            if (abort) begin
               abort = 1'b0;
               if (sb_q.size() != 0) void'(sb_q.pop_front());
            end else if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_commit: got busy period %0d expected none", bcnt);
            end else begin
               e = sb_q.pop_front();
               chk("commit_hi", hi, e.hi);
               chk("commit_lo", lo, e.lo);
               chk("busy_len", 32'(bcnt), 32'(e.lat));
            end
            bcnt = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] ra, input logic [31:0] rb);
      @(negedge clk);
      start    = 1'b1;
      mdu_type = op;
      a        = ra;
      b        = rb;
      @(posedge clk);
      #1;
      start    = 1'b0;
      mdu_type = MDU_NONE;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: got busy %b expected 0", busy);
      end
   endtask

   task automatic check_rd();
      mdu_type = MDU_MFHI;
      #1 chk("rdata_mfhi", rdata, cm_hi);
      mdu_type = MDU_MFLO;
      #1 chk("rdata_mflo", rdata, cm_lo);
      mdu_type = MDU_DIV;
      #1 chk("rdata_other", rdata, 32'h0);
      mdu_type = MDU_NONE;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] ra, input logic [31:0] rb,
                         input int n_intrude);
      logic [63:0] res;
      exp_t        e;
      res = ref_op(op, ra, rb, cm_hi, cm_lo);
      if (long_op(op)) begin
         e.hi  = res[63:32];
         e.lo  = res[31:0];
         e.lat = (op == MDU_MULT || op == MDU_MULTU) ? 5 : 10;
         sb_q.push_back(e);
         drive(op, ra, rb);
         @(negedge clk);
         mdu_type = MDU_MFHI;
         #1 chk("rdata_hides_pending_hi", rdata, cm_hi);
         mdu_type = MDU_MFLO;
         #1 chk("rdata_hides_pending_lo", rdata, cm_lo);
         mdu_type = MDU_NONE;
         for (int k = 0; k < n_intrude; k++)
            drive(4'((k % 2 == 0) ? MDU_MTHI : MDU_MULT), 32'h9999 + 32'(k), 32'd7);
         wait_idle();
      end else begin
         drive(op, ra, rb);
         chk("direct_hi", hi, res[63:32]);
         chk("direct_lo", lo, res[31:0]);
         chk("direct_busy", 32'(busy), 32'h0);
      end
      cm_hi = res[63:32];
      cm_lo = res[31:0];
   endtask

   initial begin : stim
      logic [31:0] edges[5];
      logic [31:0] ra, rb;
      logic [3:0]  op;
      edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      check_rd();

      run_op(MDU_MULT,  32'hFFFFFFFE, 32'd3, 0);
      run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 0);
      run_op(MDU_DIV,   32'hFFFFFFF9, 32'd2, 0);
      run_op(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 0);
      run_op(MDU_MTHI,  32'h1234, 32'h0, 0);
      run_op(MDU_DIVU,  32'h55, 32'h0, 2);
      chk("divzero_hi_kept", hi, 32'h1234);
      check_rd();

      // Reset during the third busy cycle of a multiply.
      begin
         exp_t e;
         e.hi = '0; e.lo = '0; e.lat = 5;
         sb_q.push_back(e);
         drive(MDU_MULT, 32'd1000, 32'd1000);
         repeat (3) @(negedge clk);
         abort = 1'b1;
         reset = 1'b1;
         @(posedge clk);
         #1 reset = 1'b0;
         @(negedge clk);
         chk("abort_busy", 32'(busy), 32'h0);
         chk("abort_hi", hi, 32'h0);
         chk("abort_lo", lo, 32'h0);
         cm_hi = '0;
         cm_lo = '0;
      end
      run_op(MDU_MTLO, 32'd5, 32'd0, 0);
      mdu_type = MDU_MFLO;
      #1 chk("mflo_after_reset", rdata, 32'd5);
      mdu_type = MDU_NONE;

      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'h0 :
              ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
         run_op(op, ra, rb, (i % 5 == 0) ? 1 : 0);
         check_rd();
      end

      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width.
REQ-002 SHALL have parameter MULT_LAT, default 5, busy cycles for MULT/MULTU (>=1).
REQ-003 SHALL have parameter DIV_LAT, default 10, busy cycles for DIV/DIVU (>=1).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  issue strobe for the operation on mdu_type.
REQ-007 mdu_type  input  4  operation code: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO; 0 = none.
REQ-008 a  input  WIDTH  rs operand.
REQ-009 b  input  WIDTH  rt operand.
REQ-010 busy  output  1  long operation in progress.
REQ-011 hi  output  WIDTH  committed HI register.
REQ-012 lo  output  WIDTH  committed LO register.
REQ-013 rdata  output  WIDTH  mfhi/mflo read data.

Function
REQ-014 Two states, IDLE and BUSY; busy = (state == BUSY).
REQ-015 In IDLE, start with MULT/MULTU/DIV/DIVU: latch result into pending regs, load counter with MULT_LAT or DIV_LAT, enter BUSY next cycle.
REQ-016 Counter decrements once per BUSY cycle; busy high for exactly MULT_LAT or DIV_LAT cycles.
REQ-017 BUSY -> IDLE, with pending HI/LO committed, on the edge ending the last busy cycle.
REQ-018 start while BUSY is ignored entirely: no state, counter, HI or LO change. Upstream stalls.
REQ-019 MTHI/MTLO with start in IDLE: HI or LO = a at the next edge; busy stays 0.
REQ-020 MFHI/MFLO: rdata = hi or lo combinationally, independent of start; rdata = 0 for any other mdu_type.
REQ-021 rdata never shows pending results; it reflects committed values only.
REQ-022 MULT: signed 2*WIDTH product. MULTU: unsigned product. HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-023 DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-024 DIVU: unsigned quotient to LO, remainder to HI.
REQ-025 Signed overflow, DIV of minimum value by -1: LO = minimum value, HI = 0.
REQ-026 Divide by zero, DIV or DIVU with b = 0: full DIV_LAT busy period, HI and LO unchanged at commit.
REQ-027 start with mdu_type 0 or an undefined code: no effect.

Reset
REQ-028 reset has priority over all inputs; takes effect at the next rising clk edge.
REQ-029 Reset values: state IDLE, busy 0, counter 0, hi 0, lo 0, pending regs 0.
REQ-030 Reset mid-operation discards the pending result; the next cycle is IDLE and accepts start.

Structure
REQ-031 MDU_* opcode constants SHALL live in the shared constants include, also used by the controller.
REQ-032 Counter width SHALL be $clog2 of max(MULT_LAT, DIV_LAT) + 1.
REQ-033 Datapath SHALL be one sub-module, mdu_arith: combinational, produces {hi_next, lo_next, div_zero} from type/a/b.
REQ-034 mdu_unit SHALL hold only the FSM, counter, pending and committed registers.

Verification
REQ-035 MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-037 DIV a=-7, b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 MTHI a=0x1234 in IDLE; then DIVU b=0 -> hi stays 0x1234 after 10 busy cycles; second start during busy is ignored.
REQ-040 reset asserted in the 3rd cycle of a MULT -> next cycle busy=0, hi=lo=0; new MTLO a=5 gives lo=5; MFLO gives rdata=5.
